// File: rtl/segrun_pkg.sv
// Shared types and constants for the scrolling obstacle game: game states,
// bitmap polarity, LFSR taps and playfield geometry.
package segrun_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic OBSTACLE = 1'b0;
  localparam logic EMPTY    = 1'b1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int SCORE_WIDTH = 14;
  localparam int PLAYER_COL  = 4;

  // Fibonacci step: taps 16,14,13,11 folded into bit 0 while shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when asked, so the obstacle pattern
// advances once per scroll step rather than once per clock.
module lfsr16
  import segrun_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/obstacle_field_gen.sv
// Playfield producer for the 7-segment runner game: scrolls obstacle bitmaps,
// detects collisions and keeps score. Define OBSTACLE_SPEEDUP_EN for speedup.
module obstacle_field_gen
  import segrun_pkg::*;
#(
  parameter int          TICK_DIV  = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MIN_GAP   = 2,
  parameter int          SCORE_MAX = 9999
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   player_pos,
  output logic [5:0]             ceiling_bits,
  output logic [5:0]             floor_bits,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   show_score,
  output logic                   game_over
);

  localparam int PERIOD_W = $clog2(TICK_DIV + 1);
  localparam logic [PERIOD_W-1:0]    PERIOD_FULL = PERIOD_W'(TICK_DIV);
  localparam logic [2:0]             GAP_RELOAD  = 3'(MIN_GAP);
  localparam logic [SCORE_WIDTH-1:0] SCORE_SAT   = SCORE_WIDTH'(SCORE_MAX);

  game_state_t         state, state_next;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] period;
  logic [2:0]          gap_cnt;
  logic [15:0]         lfsr_state;
  logic                lfsr_unused;
  logic                tick, collision, advance, game_start;
  logic                new_ceil, new_floor, obstacle_placed;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .state   (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[15:2];

  assign collision  = (state == PLAY) &&
                      (player_pos ? (ceiling_bits[PLAYER_COL] == OBSTACLE)
                                  : (floor_bits[PLAYER_COL] == OBSTACLE));
  assign tick       = (state == PLAY) && (tick_cnt == period - PERIOD_W'(1));
  assign advance    = tick && !collision;
  assign game_start = (state != PLAY) && start;

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [PERIOD_W-1:0] PERIOD_STEP  = PERIOD_W'(TICK_DIV >> 3);
  localparam logic [PERIOD_W-1:0] PERIOD_FLOOR = PERIOD_W'(TICK_DIV >> 2);

  logic [6:0] cent_cnt;

  // cent_cnt tracks score mod 100, so the period shrinks as the score crosses each hundred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period   <= PERIOD_FULL;
      cent_cnt <= '0;
    end else if (game_start) begin
      period   <= PERIOD_FULL;
      cent_cnt <= '0;
    end else if (advance && (score != SCORE_SAT)) begin
      if (cent_cnt == 7'd99) begin
        cent_cnt <= '0;
        period   <= (period >= PERIOD_FLOOR + PERIOD_STEP) ? period - PERIOD_STEP
                                                           : PERIOD_FLOOR;
      end else begin
        cent_cnt <= cent_cnt + 7'd1;
      end
    end
  end
`else
  assign period = PERIOD_FULL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, OVER: if (start)     state_next = PLAY;
      PLAY:       if (collision) state_next = OVER;
      default:                   state_next = IDLE;
    endcase
  end

  // The gap counter forces empty columns after each obstacle before the LFSR gets a say.
  always_comb begin
    new_ceil  = EMPTY;
    new_floor = EMPTY;
    if (gap_cnt == 3'd0) begin
      if (lfsr_state[1:0] == 2'b00) begin
        new_ceil = OBSTACLE;
      end else if (lfsr_state[1:0] == 2'b01) begin
        new_floor = OBSTACLE;
      end
    end
    obstacle_placed = (new_ceil == OBSTACLE) || (new_floor == OBSTACLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceiling_bits <= '1;
      floor_bits   <= '1;
      score        <= '0;
      show_score   <= 1'b1;
      game_over    <= 1'b0;
      tick_cnt     <= '0;
      gap_cnt      <= GAP_RELOAD;
    end else if (game_start) begin
      ceiling_bits <= '1;
      floor_bits   <= '1;
      score        <= '0;
      show_score   <= 1'b0;
      game_over    <= 1'b0;
      tick_cnt     <= '0;
      gap_cnt      <= GAP_RELOAD;
    end else if (state == PLAY) begin
      // A collision overrides a coincident tick: the field freezes as it was.
      if (collision) begin
        show_score <= 1'b1;
        game_over  <= 1'b1;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + PERIOD_W'(1);
        if (tick) begin
          ceiling_bits <= {ceiling_bits[4:0], new_ceil};
          floor_bits   <= {floor_bits[4:0], new_floor};
          score        <= (score >= SCORE_SAT) ? SCORE_SAT : score + SCORE_WIDTH'(1);
          if (gap_cnt != 3'd0) begin
            gap_cnt <= gap_cnt - 3'd1;
          end else if (obstacle_placed) begin
            gap_cnt <= GAP_RELOAD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_field_gen.sv
// Directed bench for obstacle_field_gen: a reference model queues the expected
// outputs of every clock and each one is checked once the DUT has clocked.
module tb_obstacle_field_gen;

  localparam int          TICK_DIV  = 4;
  localparam int          MIN_GAP   = 2;
  localparam int          SCORE_MAX = 9999;
  localparam logic [15:0] SEED      = 16'hACE1;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  localparam logic [27:0] RESET_VIEW = {6'h3f, 6'h3f, 14'd0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        player_pos;
  logic [5:0]  ceiling_bits;
  logic [5:0]  floor_bits;
  logic [13:0] score;
  logic        show_score;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];

  int          m_state;
  int          m_tick;
  int          m_gap;
  int          m_score;
  logic [15:0] m_lfsr;
  logic [5:0]  m_ceil;
  logic [5:0]  m_floor;
  logic        m_show;
  logic        m_over;

  always #5 clk = ~clk;

  obstacle_field_gen #(
    .TICK_DIV  (TICK_DIV),
    .LFSR_SEED (SEED),
    .MIN_GAP   (MIN_GAP),
    .SCORE_MAX (SCORE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .player_pos   (player_pos),
    .ceiling_bits (ceiling_bits),
    .floor_bits   (floor_bits),
    .score        (score),
    .show_score   (show_score),
    .game_over    (game_over)
  );

  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [27:0] dut_view();
    return {ceiling_bits, floor_bits, score, show_score, game_over};
  endfunction

  function automatic logic [27:0] model_view();
    return {m_ceil, m_floor, 14'(m_score), m_show, m_over};
  endfunction

  // Stand on the row that has no obstacle in the player column.
  function automatic logic safe_pos();
    return (m_floor[4] == 1'b0) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_tick  = 0;
    m_gap   = MIN_GAP;
    m_score = 0;
    m_lfsr  = SEED;
    m_ceil  = 6'h3f;
    m_floor = 6'h3f;
    m_show  = 1'b1;
    m_over  = 1'b0;
  endtask

  task automatic model_clock(input logic st, input logic pp);
    logic coll, tk, nc, nf;
    coll = (m_state == M_PLAY) &&
           ((pp == 1'b0 && m_floor[4] == 1'b0) || (pp == 1'b1 && m_ceil[4] == 1'b0));
    tk   = (m_state == M_PLAY) && (m_tick == TICK_DIV - 1);
    if (m_state != M_PLAY) begin
      if (st) begin
        m_state = M_PLAY;
        m_score = 0;
        m_ceil  = 6'h3f;
        m_floor = 6'h3f;
        m_tick  = 0;
        m_gap   = MIN_GAP;
        m_show  = 1'b0;
        m_over  = 1'b0;
      end
    end else if (coll) begin
      m_state = M_OVER;
      m_show  = 1'b1;
      m_over  = 1'b1;
    end else begin
      m_tick = tk ? 0 : m_tick + 1;
      if (tk) begin
        nc = 1'b1;
        nf = 1'b1;
        if (m_gap > 0) begin
          m_gap = m_gap - 1;
        end else if (m_lfsr[1:0] == 2'b00) begin
          nc    = 1'b0;
          m_gap = MIN_GAP;
        end else if (m_lfsr[1:0] == 2'b01) begin
          nf    = 1'b0;
          m_gap = MIN_GAP;
        end
        m_ceil  = {m_ceil[4:0], nc};
        m_floor = {m_floor[4:0], nf};
        if (m_score < SCORE_MAX) m_score = m_score + 1;
        m_lfsr = ref_lfsr_step(m_lfsr);
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the model's prediction, clock, compare.
  task automatic apply_stimulus(input logic st, input logic pp);
    logic [27:0] e;
    start      = st;
    player_pos = pp;
    model_clock(st, pp);
    exp_q.push_back(model_view());
    @(posedge clk);
    #1;
    start = 1'b0;
    e = exp_q.pop_front();
    check_output("cycle", 64'(dut_view()), 64'(e));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [27:0] snap;
    logic        found;

    rst_n      = 1'b0;
    start      = 1'b0;
    player_pos = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", 64'(dut_view()), 64'(RESET_VIEW));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
    check_output("idle_hold", 64'(dut_view()), 64'(RESET_VIEW));

    apply_stimulus(1'b1, safe_pos());
    check_output("start_show", 64'(show_score), 64'(1'b0));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, safe_pos());
    check_output("pre_tick_score", 64'(score), 64'(14'd0));
    apply_stimulus(1'b0, safe_pos());
    check_output("first_tick_score", 64'(score), 64'(14'd1));
    check_output("gap_col0", 64'({ceiling_bits[0], floor_bits[0]}), 64'(2'b11));
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, safe_pos());
    check_output("gap_col1", 64'({ceiling_bits[1:0], floor_bits[1:0], score}),
                 64'({4'hf, 14'd2}));

    apply_stimulus(1'b1, safe_pos());
    check_output("start_ignored", 64'({show_score, score}), 64'({1'b0, 14'd2}));

    for (int n = 0; n < 45000 && m_score < SCORE_MAX; n++) apply_stimulus(1'b0, safe_pos());
    check_output("reached_max", 64'({game_over, score}), 64'({1'b0, 14'd9999}));
    for (int i = 0; i < 10 * TICK_DIV; i++) apply_stimulus(1'b0, safe_pos());
    check_output("no_wrap", 64'(score), 64'(14'd9999));

    found = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (m_floor[4] == 1'b0) begin
        apply_stimulus(1'b0, 1'b0);
        found = 1'b1;
        break;
      end
      apply_stimulus(1'b0, safe_pos());
    end
    check_output("floor_obstacle_found", 64'(found), 64'(1'b1));
    check_output("over_flags", 64'({game_over, show_score}), 64'(2'b11));
    snap = model_view();
    for (int i = 0; i < 100; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
    check_output("over_frozen", 64'(dut_view()), 64'(snap));

    apply_stimulus(1'b1, 1'b0);
    check_output("restart", 64'(dut_view()), 64'({6'h3f, 6'h3f, 14'd0, 1'b0, 1'b0}));

    found = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (m_state == M_PLAY && m_tick == TICK_DIV - 1 &&
          (m_floor[4] == 1'b0 || m_ceil[4] == 1'b0)) begin
        snap = model_view();
        apply_stimulus(1'b0, (m_floor[4] == 1'b0) ? 1'b0 : 1'b1);
        found = 1'b1;
        break;
      end
      apply_stimulus(1'b0, safe_pos());
    end
    check_output("tick_obstacle_found", 64'(found), 64'(1'b1));
    check_output("tick_collision_freeze", 64'({ceiling_bits, floor_bits, score, game_over}),
                 64'({snap[27:2], 1'b1}));

    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, safe_pos());
    check_output("mid_score", 64'({game_over, score}), 64'({1'b0, 14'd3}));

    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check_output("async_reset", 64'(dut_view()), 64'(RESET_VIEW));
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    check_output("reset_hold", 64'(dut_view()), 64'(RESET_VIEW));
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    check_output("start_lost", 64'({show_score, game_over}), 64'(2'b10));

    apply_stimulus(1'b1, safe_pos());
    for (int i = 0; i < 40 * TICK_DIV; i++) apply_stimulus(1'b0, safe_pos());
    check_output("reseeded_score", 64'(score), 64'(14'd40));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
